// File: rtl/cr_kme_fifo_writer.sv
// rtl/cr_kme_fifo_writer.sv - serialises NUM_WORDS x 32-bit blocks into 34-bit {sot,eot,data} FIFO words
// Keeps a saturating stall-cycle counter and a sticky FIFO overflow flag.
module cr_kme_fifo_writer #(
   parameter int NUM_WORDS = 4,
   parameter int CNT_W     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   blk_valid,
   output logic                   blk_ready,
   input  logic [32*NUM_WORDS-1:0] blk_data,
   output logic [33:0]            fifo_in,
   output logic                   fifo_in_valid,
   input  logic                   fifo_in_stall,
   input  logic                   fifo_overflow,
   input  logic                   clr_stats,
   output logic                   busy,
   output logic [CNT_W-1:0]       stall_cnt,
   output logic                   ovf_sticky
);

   localparam int IDX_W = $clog2(NUM_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                   state;
   state_t                   state_nxt;
   logic [IDX_W-1:0]         idx;
   logic [32*NUM_WORDS-1:0]  shreg;
   logic                     last_word;
   logic                     write;
   logic                     accept;

   assign last_word = (idx == LAST_IDX);
   assign write     = fifo_in_valid;
   assign accept    = blk_valid & blk_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A new block on the last-word write keeps us in SEND with no bubble.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (blk_valid) state_nxt = SEND;
         SEND: if (write && last_word && !blk_valid) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy          = 1'b0;
      blk_ready     = 1'b0;
      fifo_in       = '0;
      fifo_in_valid = 1'b0;
      case (state)
         IDLE: begin
            blk_ready = ~rst;
         end
         SEND: begin
            busy          = 1'b1;
            fifo_in       = {(idx == '0), last_word, shreg[31:0]};
            fifo_in_valid = ~rst & ~fifo_in_stall;
            blk_ready     = ~rst & ~fifo_in_stall & last_word;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx   <= '0;
         shreg <= '0;
      end else if (accept) begin
         shreg <= blk_data;
         idx   <= '0;
      end else if (write) begin
         shreg <= {32'h0, shreg[32*NUM_WORDS-1:32]};
         idx   <= last_word ? '0 : idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt  <= '0;
         ovf_sticky <= 1'b0;
      end else begin
         if (clr_stats) begin
            stall_cnt <= '0;
         end else if (busy && fifo_in_stall && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         // Overflow set wins over a same-cycle clear.
         if (fifo_overflow) begin
            ovf_sticky <= 1'b1;
         end else if (clr_stats) begin
            ovf_sticky <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cr_kme_fifo_writer.sv
// tb/tb_cr_kme_fifo_writer.sv - self-checking bench for cr_kme_fifo_writer
module tb_cr_kme_fifo_writer;

   localparam int NW  = 4;
   localparam int CW  = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              blk_valid;
   logic              blk_ready;
   logic [32*NW-1:0]  blk_data;
   logic [33:0]       fifo_in;
   logic              fifo_in_valid;
   logic              fifo_in_stall;
   logic              fifo_overflow;
   logic              clr_stats;
   logic              busy;
   logic [CW-1:0]     stall_cnt;
   logic              ovf_sticky;

   int checks = 0;
   int errors = 0;

   cr_kme_fifo_writer #(.NUM_WORDS(NW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(blk_ready),
      .blk_data(blk_data), .fifo_in(fifo_in), .fifo_in_valid(fifo_in_valid),
      .fifo_in_stall(fifo_in_stall), .fifo_overflow(fifo_overflow),
      .clr_stats(clr_stats), .busy(busy), .stall_cnt(stall_cnt),
      .ovf_sticky(ovf_sticky)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        bv;
      logic        stall;
      logic        exp_ready;
      logic        exp_valid;
      logic        exp_busy;
      logic [33:0] exp_fifo;
      logic [7:0]  exp_cnt;
   } vec_t;

   localparam logic [32*NW-1:0] BLK_A = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
   localparam logic [32*NW-1:0] BLK_B = {32'h8888_8888, 32'h7777_7777, 32'h6666_6666, 32'h5555_5555};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
   task automatic cyc();
      @(negedge clk);
   endtask

   function automatic logic [33:0] word_of(input logic [32*NW-1:0] blk, input int i);
      return {(i == 0), (i == NW - 1), blk[32*i +: 32]};
   endfunction

   vec_t vecs[15];
   logic [33:0] mq[$];
   logic [32*NW-1:0] rblk;
   int   mcnt;
   logic mov;
   logic e_ready, e_valid, e_busy;
   logic [33:0] e_fifo;
   int   writes;

   initial begin
      rst = 1'b1; blk_valid = 1'b0; blk_data = '0; fifo_in_stall = 1'b0;
      fifo_overflow = 1'b0; clr_stats = 1'b0;

      //            bv st  rdy val bsy fifo              cnt
      vecs[0]  = '{1, 0,  1,  0,  0,  34'h0,            0};
      vecs[1]  = '{0, 0,  0,  1,  1,  34'h2_1111_1111,  0};
      vecs[2]  = '{0, 0,  0,  1,  1,  34'h0_2222_2222,  0};
      vecs[3]  = '{0, 0,  0,  1,  1,  34'h0_3333_3333,  0};
      vecs[4]  = '{0, 0,  1,  1,  1,  34'h1_4444_4444,  0};
      vecs[5]  = '{0, 0,  1,  0,  0,  34'h0,            0};
      vecs[6]  = '{1, 0,  1,  0,  0,  34'h0,            0};
      vecs[7]  = '{0, 0,  0,  1,  1,  34'h2_1111_1111,  0};
      vecs[8]  = '{0, 1,  0,  0,  1,  34'h0_2222_2222,  0};
      vecs[9]  = '{0, 1,  0,  0,  1,  34'h0_2222_2222,  1};
      vecs[10] = '{0, 1,  0,  0,  1,  34'h0_2222_2222,  2};
      vecs[11] = '{0, 0,  0,  1,  1,  34'h0_2222_2222,  3};
      vecs[12] = '{0, 0,  0,  1,  1,  34'h0_3333_3333,  3};
      vecs[13] = '{0, 0,  1,  1,  1,  34'h1_4444_4444,  3};
      vecs[14] = '{0, 0,  1,  0,  0,  34'h0,            3};

      // Reset: handshake outputs forced low while rst is high.
      cyc(); blk_valid = 1'b1; #1;
      chk("rst_ready", blk_ready, 0);
      chk("rst_valid", fifo_in_valid, 0);
      cyc(); rst = 1'b0; blk_valid = 1'b0; #1;
      chk("rst_cnt", stall_cnt, 0);
      chk("rst_ovf", ovf_sticky, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready_after", blk_ready, 1);

      // Single block and stall-at-word-1 table.
      blk_data = BLK_A;
      for (int i = 0; i < 15; i++) begin
         if (i != 0) cyc();
         blk_valid = vecs[i].bv; fifo_in_stall = vecs[i].stall; #1;
         chk($sformatf("tbl%0d_ready", i), blk_ready, vecs[i].exp_ready);
         chk($sformatf("tbl%0d_valid", i), fifo_in_valid, vecs[i].exp_valid);
         chk($sformatf("tbl%0d_busy", i), busy, vecs[i].exp_busy);
         chk($sformatf("tbl%0d_fifo", i), fifo_in, vecs[i].exp_fifo);
         chk($sformatf("tbl%0d_cnt", i), stall_cnt, vecs[i].exp_cnt);
      end

      // Back-to-back blocks with blk_valid held.
      cyc(); clr_stats = 1'b1; blk_valid = 1'b1; blk_data = BLK_A; fifo_in_stall = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cyc(); clr_stats = 1'b0;
         blk_valid = (k < 4); blk_data = BLK_B; #1;
         chk($sformatf("b2b%0d_valid", k), fifo_in_valid, 1);
         chk($sformatf("b2b%0d_fifo", k), fifo_in, (k < 4) ? word_of(BLK_A, k) : word_of(BLK_B, k - 4));
         chk($sformatf("b2b%0d_ready", k), blk_ready, (k % 4) == 3);
      end
      cyc(); blk_valid = 1'b0; #1;
      chk("b2b_idle", busy, 0);

      // Saturating stall counter, then clear.
      blk_valid = 1'b1; blk_data = BLK_B;
      cyc(); blk_valid = 1'b0; fifo_in_stall = 1'b1;
      writes = 0;
      for (int k = 0; k < (1 << CW) + 5; k++) begin
         cyc(); #1;
         if (fifo_in_valid || blk_ready) writes++;
      end
      chk("sat_no_write", writes, 0);
      chk("sat_cnt", stall_cnt, 8'hFF);
      clr_stats = 1'b1;
      cyc(); clr_stats = 1'b0; #1;
      chk("sat_clr", stall_cnt, 0);
      fifo_in_stall = 1'b0; #1;
      chk("sat_resume", fifo_in, word_of(BLK_B, 0));
      repeat (4) cyc();
      #1 chk("sat_idle", busy, 0);

      // Overflow set beats clear.
      fifo_overflow = 1'b1; clr_stats = 1'b1;
      cyc(); fifo_overflow = 1'b0; #1;
      chk("ovf_set", ovf_sticky, 1);
      cyc(); clr_stats = 1'b0; #1;
      chk("ovf_clr", ovf_sticky, 0);

      // Reset mid-block discards the block.
      blk_valid = 1'b1; blk_data = BLK_A;
      cyc(); blk_valid = 1'b0;
      cyc();
      cyc(); rst = 1'b1; #1;
      chk("mid_rst_valid", fifo_in_valid, 0);
      chk("mid_rst_ready", blk_ready, 0);
      cyc(); rst = 1'b0; #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready_after", blk_ready, 1);
      blk_valid = 1'b1; blk_data = BLK_B;
      cyc(); blk_valid = 1'b0; #1;
      chk("mid_rst_sot", fifo_in, word_of(BLK_B, 0));
      chk("mid_rst_sot_valid", fifo_in_valid, 1);

      // Randomised run against a word-queue reference model.
      cyc(); rst = 1'b1;
      cyc(); rst = 1'b0;
      mq.delete(); mcnt = 0; mov = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         cyc();
         rst           = ($urandom_range(0, 199) == 0);
         blk_valid     = ($urandom_range(0, 1) == 1);
         fifo_in_stall = ($urandom_range(0, 9) < 3);
         clr_stats     = ($urandom_range(0, 19) == 0);
         fifo_overflow = ($urandom_range(0, 19) == 0);
         rblk = {$urandom, $urandom, $urandom, $urandom};
         blk_data = rblk;
         #1;
         e_busy  = (mq.size() > 0);
         e_valid = !rst && e_busy && !fifo_in_stall;
         e_ready = !rst && (mq.size() == 0 || (mq.size() == 1 && !fifo_in_stall));
         e_fifo  = e_busy ? mq[0] : 34'h0;
         chk("rnd_ready", blk_ready, e_ready);
         chk("rnd_valid", fifo_in_valid, e_valid);
         chk("rnd_busy", busy, e_busy);
         chk("rnd_fifo", fifo_in, e_fifo);
         chk("rnd_cnt", stall_cnt, mcnt[CW-1:0]);
         chk("rnd_ovf", ovf_sticky, mov);
         if (rst) begin
            mq.delete(); mcnt = 0; mov = 1'b0;
         end else begin
            if (e_valid) void'(mq.pop_front());
            if (blk_valid && e_ready)
               for (int i = 0; i < NW; i++) mq.push_back(word_of(rblk, i));
            if (clr_stats) mcnt = 0;
            else if (e_busy && fifo_in_stall && mcnt < (1 << CW) - 1) mcnt++;
            if (fifo_overflow) mov = 1'b1;
            else if (clr_stats) mov = 1'b0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
